// File: rtl/cpu_run_sequencer_if.sv
// Control/status bundle between the run sequencer and the board/datapath.
// master = sequencer side, slave = board/datapath side.
interface cpu_run_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             tick;
  logic             step_mode;
  logic             bt_step;
  logic             hard_reset;
  logic             sleep;
  logic             await;
  logic             cpu_clk;
  logic             hard_reset_o;
  logic             stall_o;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  tick, step_mode, bt_step,
    input  hard_reset, sleep, await,
    output cpu_clk, hard_reset_o, stall_o,
    output state, cycle_count
  );

  modport slave (
    output tick, step_mode, bt_step,
    output hard_reset, sleep, await,
    input  cpu_clk, hard_reset_o, stall_o,
    input  state, cycle_count
  );
endinterface

// File: rtl/cpu_run_sequencer.sv
// CPU clock/reset sequencer: reset burst, free run, single step
// and sleep/await stalls, paced by divider ticks.
module cpu_run_sequencer #(
  parameter int RESET_EDGES    = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                bt_reset,
  cpu_run_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_SLEEP = 3'd3,
    S_AWAIT = 3'd4,
    S_STEP  = 3'd5
  } state_e;

  localparam logic [3:0] EDGE_MAX = 4'(RESET_EDGES);
  localparam logic [7:0] DB_MAX   = 8'(DEBOUNCE_TICKS);

  state_e           state_q, state_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             hrst_q, hrst_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_q, edge_d;
  logic             pend_q, pend_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic [7:0]       db_q, db_d;
  logic             rise;

  always_comb begin
    sync1_d = bus.bt_step;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    db_d    = db_q;
    rise    = 1'b0;
    if (bus.tick) begin
      if (sync2_q != lvl_q) begin
        if (db_q + 8'd1 == DB_MAX) begin
          lvl_d = ~lvl_q;
          db_d  = '0;
          rise  = ~lvl_q;
        end else begin
          db_d = db_q + 8'd1;
        end
      end else begin
        db_d = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_clk_d = cpu_clk_q;
    hrst_d    = hrst_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    pend_d    = pend_q | rise;
    if (bus.hard_reset && state_q != S_RST) begin
      state_d   = S_RST;
      cpu_clk_d = 1'b0;
      hrst_d    = 1'b1;
      edge_d    = '0;
      pend_d    = 1'b0;
    end else if (bus.tick) begin
      unique case (state_q)
        S_RST: begin
          if (cpu_clk_q) begin
            cpu_clk_d = 1'b0;
            if (edge_q == EDGE_MAX) begin
              state_d = S_LOW;
              hrst_d  = 1'b0;
              edge_d  = '0;
            end
          end else begin
            cpu_clk_d = 1'b1;
            edge_d    = edge_q + 4'd1;
          end
        end
        S_LOW: begin
          if (bus.sleep) begin
            state_d = S_SLEEP;
          end else if (bus.await) begin
            state_d = S_AWAIT;
          end else if (bus.step_mode && !pend_q) begin
            state_d = S_STEP;
          end else begin
            state_d   = S_HIGH;
            cpu_clk_d = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            pend_d    = 1'b0;
          end
        end
        S_HIGH: begin
          state_d   = S_LOW;
          cpu_clk_d = 1'b0;
        end
        S_SLEEP: begin
          if (!bus.sleep) state_d = S_LOW;
        end
        S_AWAIT: begin
          if (bus.sleep) begin
            state_d = S_SLEEP;
          end else if (!bus.await) begin
            state_d = S_LOW;
          end
        end
        S_STEP: begin
          if (pend_q || !bus.step_mode) state_d = S_LOW;
        end
        default: begin
          state_d   = S_RST;
          cpu_clk_d = 1'b0;
          hrst_d    = 1'b1;
          edge_d    = '0;
        end
      endcase
    end
    stall_d = (state_d == S_SLEEP) || (state_d == S_AWAIT);
  end

  always_ff @(posedge clk or negedge bt_reset) begin
    if (!bt_reset) begin
      state_q   <= S_RST;
      cpu_clk_q <= 1'b0;
      hrst_q    <= 1'b1;
      stall_q   <= 1'b0;
      cnt_q     <= '0;
      edge_q    <= '0;
      pend_q    <= 1'b0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      lvl_q     <= 1'b0;
      db_q      <= '0;
    end else begin
      state_q   <= state_d;
      cpu_clk_q <= cpu_clk_d;
      hrst_q    <= hrst_d;
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      lvl_q     <= lvl_d;
      db_q      <= db_d;
    end
  end

  assign bus.cpu_clk      = cpu_clk_q;
  assign bus.hard_reset_o = hrst_q;
  assign bus.stall_o      = stall_q;
  assign bus.state        = state_q;
  assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: directed scenarios plus random phase,
// compared every cycle against a tick-level behavioural model.
module tb_cpu_run_sequencer;
  localparam int RE = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic bt_reset = 1'b1;
  logic tick = 1'b0;
  logic step_mode = 1'b0;
  logic bt_step = 1'b0;
  logic hard_reset = 1'b0;
  logic sleep = 1'b0;
  logic aw = 1'b0;

  int errors = 0;
  int checks = 0;

  cpu_run_sequencer_if #(.CNT_W(32)) ifa ();
  cpu_run_sequencer_if #(.CNT_W(4))  ifb ();

  assign ifa.tick       = tick;
  assign ifa.step_mode  = step_mode;
  assign ifa.bt_step    = bt_step;
  assign ifa.hard_reset = hard_reset;
  assign ifa.sleep      = sleep;
  assign ifa.await      = aw;
  assign ifb.tick       = tick;
  assign ifb.step_mode  = step_mode;
  assign ifb.bt_step    = bt_step;
  assign ifb.hard_reset = hard_reset;
  assign ifb.sleep      = sleep;
  assign ifb.await      = aw;

  cpu_run_sequencer #(
    .RESET_EDGES(RE), .DEBOUNCE_TICKS(DB), .CNT_W(32)
  ) dut_a (
    .clk(clk), .bt_reset(bt_reset), .bus(ifa)
  );

  cpu_run_sequencer #(
    .RESET_EDGES(RE), .DEBOUNCE_TICKS(DB), .CNT_W(4)
  ) dut_b (
    .clk(clk), .bt_reset(bt_reset), .bus(ifb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Tick pacing: every 4th clk, or random in the random phase
  int cyc = 0;
  bit rand_tick = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rand_tick) tick = ($urandom_range(0, 2) == 0);
    else           tick = (cyc % 4 == 0);
  end

  // Reference model, one step per clk edge
  int m_st = 0;
  bit m_clk = 1'b0, m_hr = 1'b1, m_stall = 1'b0, m_pend = 1'b0;
  bit m_s1 = 1'b0, m_s2 = 1'b0, m_lvl = 1'b0;
  int m_run = 0, m_ph = 0;
  longint unsigned m_cnt = 0;

  always @(posedge clk or negedge bt_reset) begin
    bit rise, pend_old;
    if (!bt_reset) begin
      m_st = 0; m_clk = 0; m_hr = 1; m_stall = 0; m_pend = 0;
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_ph = 0; m_cnt = 0;
    end else begin
      rise = 1'b0;
      pend_old = m_pend;
      if (tick) begin
        if (m_s2 != m_lvl) begin
          m_run++;
          if (m_run == DB) begin
            m_lvl = !m_lvl;
            m_run = 0;
            rise = m_lvl;
          end
        end else begin
          m_run = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = bt_step;
      if (hard_reset && m_st != 0) begin
        m_st = 0; m_clk = 0; m_hr = 1; m_ph = 0; m_pend = 0;
      end else begin
        m_pend = pend_old | rise;
        if (tick) begin
          case (m_st)
            0: begin
              m_ph++;
              if (m_ph == 2 * RE) begin
                m_st = 1; m_hr = 0; m_clk = 0; m_ph = 0;
              end else begin
                m_clk = m_ph[0];
              end
            end
            1: begin
              if (sleep)                         m_st = 3;
              else if (aw)                       m_st = 4;
              else if (step_mode && !pend_old)   m_st = 5;
              else begin
                m_clk = 1; m_cnt++; m_pend = 0; m_st = 2;
              end
            end
            2: begin m_clk = 0; m_st = 1; end
            3: if (!sleep) m_st = 1;
            4: begin
              if (sleep)    m_st = 3;
              else if (!aw) m_st = 1;
            end
            5: if (pend_old || !step_mode) m_st = 1;
            default: m_st = 0;
          endcase
        end
      end
      m_stall = (m_st == 3) || (m_st == 4);
    end
  end

  // Cycle-by-cycle comparison and cpu_clk edge bookkeeping
  bit chk_en = 1'b0;
  bit prev_clk = 1'b0;
  int rst_edges = 0, run_edges = 0;
  longint last_rise = 0, rise_gap = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", ifa.state, m_st);
      chk("cpu_clk", ifa.cpu_clk, m_clk);
      chk("hard_reset_o", ifa.hard_reset_o, m_hr);
      chk("stall_o", ifa.stall_o, m_stall);
      chk("cycle_count", ifa.cycle_count, m_cnt[31:0]);
      chk("state_b", ifb.state, m_st);
      chk("cycle_count_b", ifb.cycle_count, m_cnt[3:0]);
      if (ifa.cpu_clk && !prev_clk) begin
        if (ifa.hard_reset_o) rst_edges++;
        else                  run_edges++;
        rise_gap  = $time - last_rise;
        last_rise = $time;
      end
      prev_clk = ifa.cpu_clk;
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    int b = 0;
    while (k < n && b < 400) begin
      @(posedge clk);
      b++;
      if (tick) k++;
    end
    #1;
    if (k < n) chk("tick_timeout", k, n);
  endtask

  task automatic wait_state(input int s, input int budget);
    int b = 0;
    while (ifa.state !== 3'(s) && b < budget) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("wait_state", ifa.state, s);
  endtask

  task automatic wait_cnt(input int c, input int st, input int budget);
    int b = 0;
    while (!(ifa.cycle_count == c && ifa.state == 3'(st)) && b < budget) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("wait_cnt", ifa.cycle_count, c);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, ifa.state, 0);
    chk({tag, "_cpu_clk"}, ifa.cpu_clk, 0);
    chk({tag, "_hr"}, ifa.hard_reset_o, 1);
    chk({tag, "_stall"}, ifa.stall_o, 0);
    chk({tag, "_cnt"}, ifa.cycle_count, 0);
    chk({tag, "_cnt_b"}, ifb.cycle_count, 0);
  endtask

  initial begin
    #1 bt_reset = 1'b0;
    #2 chk_reset_vals("por");
    chk_en = 1'b1;
    @(negedge clk);
    bt_reset = 1'b1;

    // Reset burst: exactly RE edges with hard_reset_o high
    rst_edges = 0;
    run_edges = 0;
    wait_state(1, 100);
    chk("rst_edges", rst_edges, RE);
    chk("rst_done_hr", ifa.hard_reset_o, 0);
    chk("rst_done_cnt", ifa.cycle_count, 0);

    // Free run: 10 ticks give 5 edges, 2 ticks apart
    run_edges = 0;
    wait_ticks(10);
    chk("run_edges", run_edges, 5);
    chk("run_cnt", ifa.cycle_count, 5);
    chk("run_period", rise_gap, 80);

    // Await stall, then release
    aw = 1'b1;
    wait_ticks(1);
    chk("await_state", ifa.state, 4);
    chk("await_stall", ifa.stall_o, 1);
    wait_ticks(5);
    chk("await_hold_state", ifa.state, 4);
    chk("await_hold_clk", ifa.cpu_clk, 0);
    aw = 1'b0;
    run_edges = 0;
    wait_ticks(1);
    chk("await_exit_state", ifa.state, 1);
    chk("await_exit_clk", ifa.cpu_clk, 0);
    wait_ticks(1);
    chk("await_edge", ifa.cpu_clk, 1);
    wait_ticks(1);
    sleep = 1'b1;
    aw = 1'b1;
    wait_ticks(1);
    chk("sleep_prio", ifa.state, 3);
    chk("sleep_stall", ifa.stall_o, 1);
    sleep = 1'b0;
    aw = 1'b0;
    wait_ticks(1);
    chk("sleep_exit", ifa.state, 1);

    // Single step: bounce, clean press, hold, release
    step_mode = 1'b1;
    wait_ticks(1);
    chk("step_wait", ifa.state, 5);
    run_edges = 0;
    repeat (8) begin
      bt_step = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("bounce_edges", run_edges, 0);
    bt_step = 1'b1;
    wait_ticks(12);
    chk("press_edges", run_edges, 1);
    chk("press_cnt", ifa.cycle_count, 7);
    bt_step = 1'b0;
    wait_ticks(8);
    chk("release_edges", run_edges, 1);
    chk("release_state", ifa.state, 5);
    step_mode = 1'b0;
    wait_ticks(1);
    chk("step_exit", ifa.state, 1);

    // Narrow counter wraps at 16
    wait_cnt(17, 2, 400);
    chk("cnt4_wrap", ifb.cycle_count, 1);

    // Hard reset in HIGH keeps the cycle count
    wait_cnt(37, 2, 600);
    hard_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("hr_state", ifa.state, 0);
    chk("hr_cpu_clk", ifa.cpu_clk, 0);
    chk("hr_hr_o", ifa.hard_reset_o, 1);
    rst_edges = 0;
    repeat (2) @(posedge clk);
    #1 hard_reset = 1'b0;
    wait_state(1, 200);
    chk("hr_edges", rst_edges, RE);
    chk("hr_cnt", ifa.cycle_count, 37);

    // Random phase
    rand_tick = 1'b1;
    repeat (3000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 39) == 0) step_mode = !step_mode;
      if ($urandom_range(0, 29) == 0) sleep = !sleep;
      if ($urandom_range(0, 19) == 0) aw = !aw;
      if ($urandom_range(0, 7) == 0)  bt_step = !bt_step;
      hard_reset = ($urandom_range(0, 299) == 0);
    end
    rand_tick = 1'b0;
    step_mode = 1'b0;
    sleep = 1'b0;
    aw = 1'b0;
    bt_step = 1'b0;
    hard_reset = 1'b0;

    // Asynchronous reset in the middle of a HIGH phase
    wait_state(2, 500);
    #2 bt_reset = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    bt_reset = 1'b1;
    wait_state(1, 100);
    chk("async_cnt", ifa.cycle_count, 0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
